acc_mem_arbiter: RTL and testbench

- Shares the single accelerator-side Data Memory port among NUM_ACC accelerator control units.
- Each control unit holds a read request (512-bit line) or write request (32-bit word) until it sees a one-cycle read_data_valid or write_done pulse.
- Grants go round-robin, one transaction at a time.
- The CPU has priority: no new grant starts while cpu_mem_busy is high.

---
 rtl/acc_mem_if.sv | 42 ++++
 rtl/acc_mem_arbiter.sv | 125 ++++++++++++
 tb/tb_acc_mem_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/acc_mem_if.sv
// Accelerator <-> shared Data Memory port bundle. The arbiter sits on the slave
// modport; requesters, the CPU-busy source and the memory sit on the master side.
interface acc_mem_if #(
  parameter int NUM_ACC   = 4,
  parameter int ADDR_W    = 16,
  parameter int RD_DATA_W = 512,
  parameter int WR_DATA_W = 32
);
  localparam int IDW = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1;

  logic [NUM_ACC-1:0]                acc_read_en;
  logic [NUM_ACC-1:0][ADDR_W-1:0]    acc_read_addr;
  logic [NUM_ACC-1:0]                acc_write_en;
  logic [NUM_ACC-1:0][ADDR_W-1:0]    acc_write_addr;
  logic [NUM_ACC-1:0][WR_DATA_W-1:0] acc_write_data;
  logic [RD_DATA_W-1:0]              acc_read_data;
  logic [NUM_ACC-1:0]                acc_read_data_valid;
  logic [NUM_ACC-1:0]                acc_write_done;
  logic                              cpu_mem_busy;
  logic                              mem_rd_en;
  logic [ADDR_W-1:0]                 mem_rd_addr;
  logic [RD_DATA_W-1:0]              mem_rd_data;
  logic                              mem_wr_en;
  logic [ADDR_W-1:0]                 mem_wr_addr;
  logic [WR_DATA_W-1:0]              mem_wr_data;
  logic [IDW-1:0]                    grant_id;
  logic                              busy;

  modport slave (
    input  acc_read_en, acc_read_addr, acc_write_en, acc_write_addr, acc_write_data,
           cpu_mem_busy, mem_rd_data,
    output acc_read_data, acc_read_data_valid, acc_write_done,
           mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data, grant_id, busy
  );

  modport master (
    output acc_read_en, acc_read_addr, acc_write_en, acc_write_addr, acc_write_data,
           cpu_mem_busy, mem_rd_data,
    input  acc_read_data, acc_read_data_valid, acc_write_done,
           mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data, grant_id, busy
  );
endinterface

// File: rtl/acc_mem_arbiter.sv
// Round-robin arbiter sharing one Data Memory port among NUM_ACC accelerator
// control units; one transaction in flight, CPU activity blocks new grants.
module acc_mem_arbiter #(
  parameter int NUM_ACC        = 4,
  parameter int ADDR_W         = 16,
  parameter int RD_DATA_W      = 512,
  parameter int WR_DATA_W      = 32,
  parameter int MEM_RD_LATENCY = 2
) (
  input logic       clk,
  input logic       rst_n,
  acc_mem_if.slave  bus
);
  localparam int IDW = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1;
  localparam int CW  = $clog2(MEM_RD_LATENCY + 1);

  typedef enum logic [2:0] {IDLE, ISSUE_RD, RD_WAIT, ISSUE_WR, RESP} state_e;

  state_e               state_q, state_d;
  logic [IDW-1:0]       rr_q, rr_d, id_q, id_d;
  logic                 rd_q, rd_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [WR_DATA_W-1:0] wdata_q, wdata_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [RD_DATA_W-1:0] rdata_q, rdata_d;

  logic [NUM_ACC-1:0]   pend;
  logic                 found;
  logic [IDW-1:0]       sel, cand;
  int                   pick_idx;

  assign pend = bus.acc_read_en | bus.acc_write_en;

  // First pending requester at or after rr_q, wrapping.
  always_comb begin
    found    = 1'b0;
    sel      = rr_q;
    cand     = '0;
    pick_idx = 0;
    for (int k = 0; k < NUM_ACC; k++) begin
      pick_idx = (int'(rr_q) + k) % NUM_ACC;
      cand     = IDW'(pick_idx);
      if (!found && pend[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    id_d    = id_q;
    rd_d    = rd_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (!bus.cpu_mem_busy && found) begin
          id_d    = sel;
          rr_d    = (sel == IDW'(NUM_ACC - 1)) ? '0 : sel + 1'b1;
          // Read wins when both are raised; the write gets a later grant.
          rd_d    = bus.acc_read_en[sel];
          addr_d  = bus.acc_read_en[sel] ? bus.acc_read_addr[sel] : bus.acc_write_addr[sel];
          wdata_d = bus.acc_write_data[sel];
          state_d = bus.acc_read_en[sel] ? ISSUE_RD : ISSUE_WR;
        end
      end
      ISSUE_RD: begin
        cnt_d   = '0;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (cnt_q == CW'(MEM_RD_LATENCY - 1)) begin
          rdata_d = bus.mem_rd_data;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ISSUE_WR: state_d = RESP;
      RESP:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= '0;
      id_q    <= '0;
      rd_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // Strobes and buses are gated so nothing toggles outside the issue cycle.
  assign bus.mem_rd_en     = (state_q == ISSUE_RD);
  assign bus.mem_rd_addr   = (state_q == ISSUE_RD) ? addr_q : '0;
  assign bus.mem_wr_en     = (state_q == ISSUE_WR);
  assign bus.mem_wr_addr   = (state_q == ISSUE_WR) ? addr_q : '0;
  assign bus.mem_wr_data   = (state_q == ISSUE_WR) ? wdata_q : '0;
  assign bus.acc_read_data = rdata_q;
  assign bus.grant_id      = id_q;
  assign bus.busy          = (state_q != IDLE);

  for (genvar g = 0; g < NUM_ACC; g++) begin : g_resp
    assign bus.acc_read_data_valid[g] = (state_q == RESP) &&  rd_q && (id_q == IDW'(g));
    assign bus.acc_write_done[g]      = (state_q == RESP) && !rd_q && (id_q == IDW'(g));
  end
endmodule

// File: tb/tb_acc_mem_arbiter.sv
// Self-checking bench: requesters and a fixed-latency memory model around the
// arbiter; a scoreboard pairs every expected grant with its strobe and pulse.
module tb_acc_mem_arbiter;
  localparam int NA  = 4;
  localparam int AW  = 16;
  localparam int RW  = 512;
  localparam int WW  = 32;
  localparam int LAT = 2;

  typedef struct {
    int          id;
    bit          rd;
    logic [AW-1:0] addr;
    logic [WW-1:0] data;
    int          due;
  } txn_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  txn_t exp_q[$];
  txn_t pend_q[$];
  txn_t mt;
  logic [NA-1:0] mon_ev;
  logic          mon_ok;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  acc_mem_if #(.NUM_ACC(NA), .ADDR_W(AW), .RD_DATA_W(RW), .WR_DATA_W(WW)) bus ();

  acc_mem_arbiter #(.NUM_ACC(NA), .ADDR_W(AW), .RD_DATA_W(RW), .WR_DATA_W(WW),
                    .MEM_RD_LATENCY(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  function automatic logic [RW-1:0] pat(input logic [AW-1:0] a);
    return {16{16'hABCD, a}};
  endfunction

  // Memory: data valid only in the cycle LAT after the strobe, garbage otherwise.
  logic [LAT-1:0]         vpipe = '0;
  logic [LAT-1:0][AW-1:0] apipe = '0;
  always @(posedge clk) begin
    vpipe[0] <= bus.mem_rd_en;
    apipe[0] <= bus.mem_rd_addr;
    for (int i = 1; i < LAT; i++) begin
      vpipe[i] <= vpipe[i-1];
      apipe[i] <= apipe[i-1];
    end
  end
  assign bus.mem_rd_data = vpipe[LAT-1] ? pat(apipe[LAT-1]) : {16{32'hDEADBEEF}};

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.mem_rd_en && bus.mem_wr_en) begin
        checks++; errors++;
        $display("FAIL both_strobes cyc=%0d", cyc);
      end
      if (bus.mem_rd_en || bus.mem_wr_en) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_strobe cyc=%0d rd=%0b wr=%0b", cyc, bus.mem_rd_en, bus.mem_wr_en);
        end else begin
          mt = exp_q.pop_front();
          mon_ok = (bus.mem_rd_en == mt.rd) && (bus.grant_id == 2'(mt.id)) &&
                   (mt.rd ? (bus.mem_rd_addr === mt.addr)
                          : (bus.mem_wr_addr === mt.addr && bus.mem_wr_data === mt.data));
          if (!mon_ok) begin
            errors++;
            $display("FAIL strobe cyc=%0d got rd=%0b id=%0d raddr=%h waddr=%h wdata=%h want rd=%0b id=%0d addr=%h data=%h",
                     cyc, bus.mem_rd_en, bus.grant_id, bus.mem_rd_addr, bus.mem_wr_addr,
                     bus.mem_wr_data, mt.rd, mt.id, mt.addr, mt.data);
          end
          mt.due = cyc + (mt.rd ? LAT + 1 : 1);
          pend_q.push_back(mt);
        end
      end
      if ((|bus.acc_read_data_valid) || (|bus.acc_write_done)) begin
        checks++;
        if (pend_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse cyc=%0d valid=%b done=%b", cyc,
                   bus.acc_read_data_valid, bus.acc_write_done);
        end else begin
          mt = pend_q.pop_front();
          mon_ev = NA'(1) << mt.id;
          mon_ok = (cyc == mt.due) &&
                   (mt.rd ? (bus.acc_read_data_valid === mon_ev && bus.acc_write_done === '0 &&
                             bus.acc_read_data === pat(mt.addr))
                          : (bus.acc_write_done === mon_ev && bus.acc_read_data_valid === '0));
          if (!mon_ok) begin
            errors++;
            $display("FAIL pulse cyc=%0d due=%0d valid=%b done=%b data_hi=%h want id=%0d rd=%0b data_hi=%h",
                     cyc, mt.due, bus.acc_read_data_valid, bus.acc_write_done,
                     bus.acc_read_data[RW-1 -: 32], mt.id, mt.rd, pat(mt.addr) >> (RW - 32));
          end
        end
      end
    end
  end

  task automatic push_exp(input int id, input bit rd, input logic [AW-1:0] a, input logic [WW-1:0] d);
    txn_t t;
    t.id = id; t.rd = rd; t.addr = a; t.data = d; t.due = 0;
    exp_q.push_back(t);
  endtask

  // Advance to the next negedge; requesters drop their request on their pulse.
  task automatic cycle();
    @(negedge clk);
    for (int i = 0; i < NA; i++)
      if (bus.acc_read_data_valid[i] || bus.acc_write_done[i]) begin
        bus.acc_read_en[i]  = 1'b0;
        bus.acc_write_en[i] = 1'b0;
      end
  endtask

  // Run until the scoreboard drains, then land on the following IDLE negedge.
  task automatic wait_idle(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || pend_q.size() != 0) && n < budget) begin
      cycle(); #1; n++;
    end
    if (exp_q.size() != 0 || pend_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL timeout outstanding=%0d in_flight=%0d", exp_q.size(), pend_q.size());
      exp_q.delete(); pend_q.delete();
    end
    cycle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) cycle();
    checks++;
    if ({bus.busy, bus.mem_rd_en, bus.mem_wr_en, |bus.acc_read_data_valid, |bus.acc_write_done} !== 5'b0) begin
      errors++; $display("FAIL reset_ctl got busy=%0b rd=%0b wr=%0b want all 0", bus.busy, bus.mem_rd_en, bus.mem_wr_en);
    end
    checks++;
    if (bus.grant_id !== '0 || bus.acc_read_data !== '0) begin
      errors++; $display("FAIL reset_regs got id=%0d data_nz=%0b want 0", bus.grant_id, |bus.acc_read_data);
    end
    checks++;
    if (bus.mem_rd_addr !== '0 || bus.mem_wr_addr !== '0 || bus.mem_wr_data !== '0) begin
      errors++; $display("FAIL reset_bus got ra=%h wa=%h wd=%h want 0", bus.mem_rd_addr, bus.mem_wr_addr, bus.mem_wr_data);
    end
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic test_single_read();
    bus.acc_read_addr[0] = 16'h1000;
    bus.acc_read_en[0]   = 1'b1;
    push_exp(0, 1'b1, 16'h1000, '0);
    cycle();
    checks++;
    if (bus.mem_rd_en !== 1'b1 || bus.mem_rd_addr !== 16'h1000 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL read_t1 got en=%0b addr=%h busy=%0b want 1 1000 1", bus.mem_rd_en, bus.mem_rd_addr, bus.busy);
    end
    repeat (3) cycle();
    checks++;
    if (bus.acc_read_data_valid !== 4'b0001 || bus.acc_read_data !== pat(16'h1000)) begin
      errors++; $display("FAIL read_t4 got valid=%b want 0001", bus.acc_read_data_valid);
    end
    cycle();
    checks++;
    if (bus.acc_read_data !== pat(16'h1000) || bus.acc_read_data_valid !== '0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL read_hold got valid=%b busy=%0b", bus.acc_read_data_valid, bus.busy);
    end
  endtask

  task automatic test_write();
    bus.acc_write_addr[2] = 16'h5000;
    bus.acc_write_data[2] = 32'h5;
    bus.acc_write_en[2]   = 1'b1;
    push_exp(2, 1'b0, 16'h5000, 32'h5);
    cycle();
    checks++;
    if (bus.mem_wr_en !== 1'b1 || bus.mem_rd_en !== 1'b0 || bus.mem_wr_addr !== 16'h5000 || bus.mem_wr_data !== 32'h5) begin
      errors++; $display("FAIL write_t1 got en=%0b addr=%h data=%h want 1 5000 5", bus.mem_wr_en, bus.mem_wr_addr, bus.mem_wr_data);
    end
    cycle();
    checks++;
    if (bus.acc_write_done !== 4'b0100 || bus.acc_read_data_valid !== '0) begin
      errors++; $display("FAIL write_t2 got done=%b valid=%b want 0100 0000", bus.acc_write_done, bus.acc_read_data_valid);
    end
    cycle();
  endtask

  task automatic test_round_robin();
    rst_n = 1'b0; cycle(); rst_n = 1'b1; cycle();
    for (int i = 0; i < NA; i++) begin
      bus.acc_read_addr[i] = AW'(16'h0100 * (i + 1));
      bus.acc_read_en[i]   = 1'b1;
      push_exp(i, 1'b1, AW'(16'h0100 * (i + 1)), '0);
    end
    wait_idle(100);
    checks++;
    if (bus.grant_id !== 2'd3) begin
      errors++; $display("FAIL rr_last got %0d want 3", bus.grant_id);
    end
    bus.acc_read_en[3] = 1'b1;
    bus.acc_read_en[0] = 1'b1;
    push_exp(0, 1'b1, 16'h0100, '0);
    push_exp(3, 1'b1, 16'h0400, '0);
    wait_idle(100);
    checks++;
    if (bus.grant_id !== 2'd3) begin
      errors++; $display("FAIL rr_wrap got %0d want 3", bus.grant_id);
    end
  endtask

  task automatic test_cpu_priority();
    bus.cpu_mem_busy     = 1'b1;
    bus.acc_read_addr[1] = 16'h1111;
    bus.acc_read_en[1]   = 1'b1;
    push_exp(1, 1'b1, 16'h1111, '0);
    for (int i = 0; i < 10; i++) begin
      cycle();
      checks++;
      if (bus.mem_rd_en !== 1'b0 || bus.mem_wr_en !== 1'b0 || bus.busy !== 1'b0) begin
        errors++; $display("FAIL cpu_block cyc=%0d got rd=%0b wr=%0b busy=%0b want 0", cyc, bus.mem_rd_en, bus.mem_wr_en, bus.busy);
      end
    end
    bus.cpu_mem_busy = 1'b0;
    cycle();
    checks++;
    if (bus.mem_rd_en !== 1'b1 || bus.grant_id !== 2'd1) begin
      errors++; $display("FAIL cpu_release got en=%0b id=%0d want 1 1", bus.mem_rd_en, bus.grant_id);
    end
    // CPU returning mid-transaction must not stall the read already issued.
    bus.cpu_mem_busy = 1'b1;
    wait_idle(20);
    bus.cpu_mem_busy = 1'b0;
  endtask

  task automatic test_seq_writes();
    for (int k = 0; k < 8; k++) begin
      bus.acc_write_addr[0] = AW'(16'h5008 + 32 * k);
      bus.acc_write_data[0] = {16'hCAFE, 16'(k)};
      bus.acc_write_en[0]   = 1'b1;
      push_exp(0, 1'b0, AW'(16'h5008 + 32 * k), {16'hCAFE, 16'(k)});
      cycle();
      checks++;
      if (bus.mem_wr_en !== 1'b1 || bus.mem_wr_addr !== AW'(16'h5008 + 32 * k)) begin
        errors++; $display("FAIL seqwr_strobe k=%0d got en=%0b addr=%h", k, bus.mem_wr_en, bus.mem_wr_addr);
      end
      cycle();
      checks++;
      if (bus.acc_write_done !== 4'b0001) begin
        errors++; $display("FAIL seqwr_done k=%0d got %b want 0001", k, bus.acc_write_done);
      end
      cycle();
    end
  endtask

  task automatic test_reset_mid_read();
    bus.acc_read_addr[0] = 16'h2000;
    bus.acc_read_en[0]   = 1'b1;
    push_exp(0, 1'b1, 16'h2000, '0);
    cycle();
    cycle();
    checks++;
    if (bus.busy !== 1'b1 || bus.mem_rd_en !== 1'b0) begin
      errors++; $display("FAIL midrd_wait got busy=%0b en=%0b want 1 0", bus.busy, bus.mem_rd_en);
    end
    rst_n = 1'b0;
    pend_q.delete();
    for (int i = 0; i < 2; i++) begin
      cycle();
      checks++;
      if (bus.busy !== 1'b0 || bus.acc_read_data_valid !== '0 || bus.acc_read_data !== '0 ||
          bus.grant_id !== '0 || bus.mem_rd_en !== 1'b0) begin
        errors++; $display("FAIL midrd_reset got busy=%0b valid=%b id=%0d data_nz=%0b want all 0",
                           bus.busy, bus.acc_read_data_valid, bus.grant_id, |bus.acc_read_data);
      end
    end
    rst_n = 1'b1;
    push_exp(0, 1'b1, 16'h2000, '0);
    wait_idle(30);
    checks++;
    if (bus.acc_read_data !== pat(16'h2000)) begin
      errors++; $display("FAIL midrd_reissue got data_hi=%h want %h", bus.acc_read_data[RW-1 -: 32], pat(16'h2000) >> (RW - 32));
    end
  endtask

  initial begin
    bus.acc_read_en    = '0;
    bus.acc_read_addr  = '0;
    bus.acc_write_en   = '0;
    bus.acc_write_addr = '0;
    bus.acc_write_data = '0;
    bus.cpu_mem_busy   = 1'b0;
    test_reset();
    test_single_read();
    test_write();
    test_round_robin();
    test_cpu_priority();
    test_seq_writes();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
